// File: rtl/operand_holder.sv
// Operand register bank: debounces the shared input bus and latches it into N operand slots.
// Optional feature macro OPERAND_HOLDER_RETRY_EN: unstable loads are held pending and retried.
module operand_holder #(
    parameter int WIDTH         = 8,
    parameter int NUM_OPS       = 2,
    parameter int STABLE_CYCLES = 2,
    parameter int IDXW          = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           din,
    input  logic [2:0]                 sel,
    input  logic [IDXW-1:0]            op_idx,
    output logic [NUM_OPS*WIDTH-1:0]   ops,
    output logic [NUM_OPS-1:0]         valid,
    output logic                       stable,
    output logic                       loaded,
    output logic                       rejected,
    output logic                       pending
);

    localparam int RW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [RW-1:0]   RUN_MAX   = RW'(STABLE_CYCLES - 1);
    localparam logic [IDXW:0]   NUM_OPS_L = (IDXW + 1)'(NUM_OPS);
    localparam logic [2:0]      CMD_LOAD    = 3'b001;
    localparam logic [2:0]      CMD_CLR_ALL = 3'b100;
    localparam logic [2:0]      CMD_CLR_ONE = 3'b101;

    function automatic logic [NUM_OPS-1:0] slot_mask(input logic [IDXW-1:0] idx);
        logic [NUM_OPS-1:0] m;
        for (int k = 0; k < NUM_OPS; k++) begin
            m[k] = (IDXW'(k) == idx);
        end
        return m;
    endfunction

    function automatic logic [NUM_OPS*WIDTH-1:0] put_slot(
        input logic [NUM_OPS*WIDTH-1:0] bank,
        input logic [NUM_OPS-1:0]       mask,
        input logic [WIDTH-1:0]         val
    );
        logic [NUM_OPS*WIDTH-1:0] b;
        for (int k = 0; k < NUM_OPS; k++) begin
            b[k*WIDTH +: WIDTH] = mask[k] ? val : bank[k*WIDTH +: WIDTH];
        end
        return b;
    endfunction

    logic [WIDTH-1:0]         samp_r;
    logic [RW-1:0]            run_r;
    logic [RW-1:0]            run_n_s;
    logic                     stable_n_s;
    logic                     idx_ok_s;
    logic [NUM_OPS-1:0]       mask_s;
    logic [NUM_OPS*WIDTH-1:0] ops_c_s;
    logic [NUM_OPS-1:0]       valid_c_s;
    logic                     loaded_c_s;
    logic [NUM_OPS*WIDTH-1:0] ops_n_s;
    logic [NUM_OPS-1:0]       valid_n_s;
    logic                     loaded_n_s;
    logic                     rejected_n_s;
`ifdef OPERAND_HOLDER_RETRY_EN
    logic [IDXW-1:0]          pend_idx_r;
    logic [IDXW-1:0]          pend_idx_n_s;
    logic                     pend_c_s;
    logic                     pend_n_s;
    logic                     commit_s;
`endif

    // Next-state decode: debounce counter, command handling and pending retry.
    always_comb begin
        if (din == samp_r) begin
            if (run_r == RUN_MAX) begin
                run_n_s = RUN_MAX;
            end else begin
                run_n_s = run_r + RW'(1);
            end
        end else begin
            run_n_s = '0;
        end
        stable_n_s = (run_n_s == RUN_MAX);

        idx_ok_s     = ({1'b0, op_idx} < NUM_OPS_L);
        mask_s       = slot_mask(op_idx);
        ops_c_s      = ops;
        valid_c_s    = valid;
        loaded_c_s   = 1'b0;
        rejected_n_s = 1'b0;
`ifdef OPERAND_HOLDER_RETRY_EN
        pend_c_s     = pending;
        pend_idx_n_s = pend_idx_r;
`endif

        case (sel)
            CMD_LOAD: begin
                if (!idx_ok_s) begin
                    rejected_n_s = 1'b1;
                end else if (stable) begin
                    ops_c_s    = put_slot(ops, mask_s, samp_r);
                    valid_c_s  = valid | mask_s;
                    loaded_c_s = 1'b1;
`ifdef OPERAND_HOLDER_RETRY_EN
                    pend_c_s   = 1'b0;
`endif
                end else begin
`ifdef OPERAND_HOLDER_RETRY_EN
                    pend_c_s     = 1'b1;
                    pend_idx_n_s = op_idx;
`else
                    rejected_n_s = 1'b1;
`endif
                end
            end
            CMD_CLR_ALL: begin
                ops_c_s   = '0;
                valid_c_s = '0;
`ifdef OPERAND_HOLDER_RETRY_EN
                pend_c_s  = 1'b0;
`endif
            end
            CMD_CLR_ONE: begin
                if (!idx_ok_s) begin
                    rejected_n_s = 1'b1;
                end else begin
                    ops_c_s   = put_slot(ops, mask_s, '0);
                    valid_c_s = valid & ~mask_s;
`ifdef OPERAND_HOLDER_RETRY_EN
                    pend_c_s  = pending && (pend_idx_r != op_idx);
`endif
                end
            end
            default: begin
                rejected_n_s = 1'b0;
            end
        endcase

`ifdef OPERAND_HOLDER_RETRY_EN
        // A surviving pending load commits on the first stable edge.
        commit_s = pending && pend_c_s && stable;
        if (commit_s) begin
            ops_n_s    = put_slot(ops_c_s, slot_mask(pend_idx_r), samp_r);
            valid_n_s  = valid_c_s | slot_mask(pend_idx_r);
            loaded_n_s = 1'b1;
            pend_n_s   = 1'b0;
        end else begin
            ops_n_s    = ops_c_s;
            valid_n_s  = valid_c_s;
            loaded_n_s = loaded_c_s;
            pend_n_s   = pend_c_s;
        end
`else
        ops_n_s    = ops_c_s;
        valid_n_s  = valid_c_s;
        loaded_n_s = loaded_c_s;
`endif
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            samp_r   <= '0;
            run_r    <= '0;
            stable   <= 1'b0;
            ops      <= '0;
            valid    <= '0;
            loaded   <= 1'b0;
            rejected <= 1'b0;
`ifdef OPERAND_HOLDER_RETRY_EN
            pending    <= 1'b0;
            pend_idx_r <= '0;
`endif
        end else begin
            samp_r   <= din;
            run_r    <= run_n_s;
            stable   <= stable_n_s;
            ops      <= ops_n_s;
            valid    <= valid_n_s;
            loaded   <= loaded_n_s;
            rejected <= rejected_n_s;
`ifdef OPERAND_HOLDER_RETRY_EN
            pending    <= pend_n_s;
            pend_idx_r <= pend_idx_n_s;
`endif
        end
    end

`ifndef OPERAND_HOLDER_RETRY_EN
    assign pending = 1'b0;
`endif

endmodule

// File: doc/operand_holder.md
# operand_holder

Parametrised operand register bank for the calculator datapath. It sits between the keypad/switch input bus and the ALU. It debounces the shared input bus by requiring the value to be identical over a configurable number of consecutive samples. On command it latches the debounced value into one of several operand slots, and it clears slots on command. It generalises the single-operand, fixed two-sample holder to N operands, arbitrary width and arbitrary stability depth, and adds valid flags and status pulses.

## Interface
Parameters:
- WIDTH, 8, operand and input bus width in bits (≥1)
- NUM_OPS, 2, number of operand slots (≥1)
- STABLE_CYCLES, 2, consecutive identical samples required before a load is accepted (≥1)
- IDXW, $clog2(NUM_OPS) (min 1), width of op_idx

Ports:
- clock  in  1  single clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- din  in  WIDTH  raw input bus, sampled every cycle
- sel  in  3  command: 3'b001 LOAD, 3'b100 CLEAR_ALL, 3'b101 CLEAR_ONE, all other codes NOP
- op_idx  in  IDXW  target slot for LOAD / CLEAR_ONE
- ops  out  NUM_OPS*WIDTH  slot k at bits [k*WIDTH +: WIDTH], registered
- valid  out  NUM_OPS  bit k set while slot k holds a loaded value
- stable  out  1  registered; 1 when the last STABLE_CYCLES samples of din are identical
- loaded  out  1  one-cycle pulse, a LOAD was committed on the previous edge
- rejected  out  1  one-cycle pulse, a command was refused on the previous edge
- pending  out  1  retry load outstanding (constant 0 unless OPERAND_HOLDER_RETRY_EN)

## Operation
- Sampler: every edge, s ← din. Run counter r (saturating at STABLE_CYCLES-1): r ← (din == s) ? min(r+1, STABLE_CYCLES-1) : 0. stable ← (next r == STABLE_CYCLES-1). With STABLE_CYCLES=1, stable is 1 from the first edge after reset.
- LOAD at edge E with op_idx < NUM_OPS:
  - If stable=1 at E: ops[op_idx] ← s, valid[op_idx] ← 1, loaded=1 for the following cycle. The value captured is s as it stood before E.
  - If stable=0: no slot change. The failed load is handled per Configuration.
- CLEAR_ALL: all ops ← 0, valid ← 0, pending cancelled. CLEAR_ONE: ops[op_idx] ← 0, valid[op_idx] ← 0. Clearing an already-empty slot is legal and silent.
- op_idx ≥ NUM_OPS with LOAD or CLEAR_ONE: no state change, rejected=1. CLEAR_ALL ignores op_idx.
- Re-LOAD of a valid slot overwrites it. Other slots are never disturbed.
- sel is level-sampled: LOAD held for k edges performs k load attempts.
- Reset (any time, including mid-pending): ops=0, valid=0, s=0, r=0, stable=0, loaded=0, rejected=0, pending=0. Asserts immediately; normal operation resumes on the first edge after deassertion.

## Timing
- din constant from edge E0 onward gives stable=1 after edge E0+STABLE_CYCLES-1. A LOAD at edge E0+STABLE_CYCLES is the earliest one accepted.
- LOAD-to-ops latency: 1 edge. loaded/rejected pulse in the cycle after the command edge and last exactly 1 cycle.
- A din change at edge E drops stable after E. A LOAD at the same edge E still uses the pre-edge stable and s.

## Configuration
- OPERAND_HOLDER_RETRY_EN defined: a LOAD refused for instability is not rejected. It arms pending with its op_idx latched. While pending, the load commits on the first edge where stable=1 (loaded pulses, pending clears).
  - A new LOAD replaces the latched op_idx.
  - CLEAR_ALL cancels pending.
  - CLEAR_ONE to the pending slot cancels pending.
- Not defined: a refused LOAD pulses rejected and is discarded. pending is tied 0.

## Test plan
- Reset, then din=8'h3C held and LOAD op_idx=0 asserted 3 edges after the change (STABLE_CYCLES=2) -> ops[7:0]=8'h3C, valid=2'b01, one loaded pulse.
- din toggles 8'h11/8'h22 every cycle with LOAD op_idx=1 -> slot 1 unchanged and valid[1]=0. Without the macro: rejected pulses on each attempt. With the macro: pending=1 until din holds 8'h22 two samples, then ops[15:8]=8'h22.
- Load slot 0=8'h05 and slot 1=8'hA0, then CLEAR_ONE op_idx=0 -> ops=16'hA000, valid=2'b10. Then CLEAR_ALL -> ops=0, valid=0.
- NUM_OPS=3, LOAD op_idx=3 -> no change, rejected pulse.
- Assert reset_n=0 mid-pending with valid=2'b11 -> all outputs 0 immediately, without waiting for a clock edge. After release, stable rises 2 edges later (STABLE_CYCLES=2) with din held.
- STABLE_CYCLES=4, WIDTH=16: din=16'hBEEF held for 3 edges and LOAD -> refused. Held for 4 edges and LOAD -> slot 0=16'hBEEF.
